// File: rtl/seq_detect_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl_if
//   Bundles the configuration, run-control, bit-stream and status signals of
//   the sequence-detector run controller.
//   master : bit-stream source / CPU side (drives cfg_*, start, stop, bit_*)
//   slave  : seq_detect_ctrl (drives bit_ready, match, match_cnt, busy, done,
//            cfg_err, state)
// -----------------------------------------------------------------------------
interface seq_detect_ctrl_if #(
  parameter int PAT_W   = 4,
  parameter int LEN_W   = 3,
  parameter int CNT_W   = 8,
  parameter int FRAME_W = 8
);
  // configuration
  logic               cfg_we;
  logic [PAT_W-1:0]   cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [FRAME_W-1:0] cfg_frame;
  // run control
  logic               start;
  logic               stop;
  // bit stream
  logic               bit_valid;
  logic               bit_in;
  logic               bit_ready;
  // status
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [1:0]         state;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_frame,
    output start, stop, bit_valid, bit_in,
    input  bit_ready, match, match_cnt, busy, done, cfg_err, state
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_frame,
    input  start, stop, bit_valid, bit_in,
    output bit_ready, match, match_cnt, busy, done, cfg_err, state
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//   Run controller for the serial sequence detectors. Holds a programmable
//   pattern (length, overlap mode, frame length) and sequences one detection
//   run over a valid-qualified bit stream. A run ends after cfg_frame accepted
//   bits (0 = unlimited) or on stop; matches are counted (saturating) and done
//   pulses for one cycle at the end of the run.
//
// Ports
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous reset, active-low
//   bus    seq_detect_ctrl_if.slave
//            cfg_we/cfg_pattern/cfg_len/cfg_overlap/cfg_frame : config (IDLE)
//            start/stop                                        : run control
//            bit_valid/bit_in/bit_ready                        : bit stream
//            match/match_cnt/busy/done/cfg_err/state           : status
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int PAT_W   = 4,
  parameter int LEN_W   = 3,
  parameter int CNT_W   = 8,
  parameter int FRAME_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_detect_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Reset configuration: detect two consecutive zeros, non-overlapping.
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(2);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,   state_d;
  logic [PAT_W-1:0]   pat_q,     pat_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic               ovl_q,     ovl_d;
  logic [FRAME_W-1:0] frame_q,   frame_d;
  // Only PAT_W-1 history bits are kept: after the next shift the oldest bit
  // falls outside any legal pattern window, so storing it would be dead logic.
  logic [PAT_W-2:0]   hist_q,    hist_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  logic [FRAME_W-1:0] bcnt_q,    bcnt_d;
  logic               match_q,   match_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               err_q,     err_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic               cfg_len_ok;
  logic               accept;
  logic [PAT_W-1:0]   hist_shift;
  logic [PAT_W-1:0]   len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [FRAME_W-1:0] bcnt_inc;
  logic               hit;
  logic               frame_end;

  assign cfg_len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN);
  assign accept     = (state_q == S_RUN) && bus.bit_valid;

  // Post-shift history: newest bit lands in bit 0, matching the pattern's
  // "bit[0] = last bit received" layout.
  assign hist_shift = {hist_q, bus.bit_in};
  assign fill_inc   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
  assign bcnt_inc   = bcnt_q + FRAME_W'(1);
  assign frame_end  = (frame_q != '0) && (bcnt_inc == frame_q);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Compare only once enough bits have arrived since the last reset of the
  // window; fill is what makes non-overlapping detection restart cleanly.
  assign hit = (fill_inc == len_q) &&
               ((hist_shift & len_mask) == (pat_q & len_mask));

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first; a path that
    // forgets one would otherwise infer a latch.
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    frame_d = frame_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_we && !cfg_len_ok) begin
          // Illegal length rejects the write and any start in the same cycle.
          err_d = 1'b1;
        end else begin
          if (bus.cfg_we) begin
            pat_d   = bus.cfg_pattern;
            len_d   = bus.cfg_len;
            ovl_d   = bus.cfg_overlap;
            frame_d = bus.cfg_frame;
          end
          if (bus.start) begin
            state_d = S_RUN;
            hist_d  = '0;
            fill_d  = '0;
            bcnt_d  = '0;
            cnt_d   = '0;
          end
        end
      end

      S_RUN: begin
        if (bus.cfg_we) begin
          err_d = 1'b1;
        end
        if (accept) begin
          hist_d = hist_shift[PAT_W-2:0];
          fill_d = fill_inc;
          bcnt_d = bcnt_inc;
          if (hit) begin
            match_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (!ovl_q) begin
              fill_d = '0;
            end
          end
        end
        // A bit accepted alongside stop is still processed above.
        if (bus.stop || (accept && frame_end)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.cfg_we) begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= RST_LEN;
      ovl_q   <= 1'b0;
      frame_q <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      bcnt_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      frame_q <= frame_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      bcnt_q  <= bcnt_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.bit_ready = (state_q == S_RUN);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cfg_err   = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//   Self-checking bench for seq_detect_ctrl. A behavioural model (bit queue and
//   window compare) predicts every status output each cycle; directed
//   sequences add hand-computed literal expectations. A second instance with
//   CNT_W=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.PAT_W(4), .LEN_W(3), .CNT_W(8), .FRAME_W(8)) bus  ();
  seq_detect_ctrl_if #(.PAT_W(4), .LEN_W(3), .CNT_W(2), .FRAME_W(8)) sbus ();

  seq_detect_ctrl #(.PAT_W(4), .LEN_W(3), .CNT_W(8), .FRAME_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seq_detect_ctrl #(.PAT_W(4), .LEN_W(3), .CNT_W(2), .FRAME_W(8)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int         m_state, m_len, m_frame, m_cnt, m_nbits, m_since;
  bit         m_ovl, m_match, m_err;
  logic [3:0] m_pat;
  bit         m_hist[$];

  task automatic model_reset();
    m_state = 0; m_len = 2; m_frame = 0; m_cnt = 0; m_nbits = 0; m_since = 0;
    m_ovl = 0; m_match = 0; m_err = 0; m_pat = 4'b0000;
    m_hist.delete();
  endtask

  // Last m_len received bits, oldest first, against pattern MSB-first.
  function automatic bit tail_matches();
    int n;
    n = m_hist.size();
    for (int k = 0; k < m_len; k++) begin
      if (m_hist[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    int ns;
    bit nm, ne;
    ns = m_state; nm = 0; ne = 0;
    case (m_state)
      0: begin
        if (bus.cfg_we && !(int'(bus.cfg_len) >= 1 && int'(bus.cfg_len) <= 4)) begin
          ne = 1;
        end else begin
          if (bus.cfg_we) begin
            m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
            m_ovl = bus.cfg_overlap; m_frame = int'(bus.cfg_frame);
          end
          if (bus.start) begin
            ns = 1; m_cnt = 0; m_since = 0; m_nbits = 0; m_hist.delete();
          end
        end
      end
      1: begin
        if (bus.cfg_we) ne = 1;
        if (bus.bit_valid) begin
          m_hist.push_back(bus.bit_in);
          m_nbits++;
          m_since++;
          if (m_since >= m_len && tail_matches()) begin
            nm = 1;
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) m_since = 0;
          end
          if (m_frame != 0 && m_nbits == m_frame) ns = 2;
        end
        if (bus.stop) ns = 2;
      end
      default: begin
        if (bus.cfg_we) ne = 1;
        ns = 0;
      end
    endcase
    m_state = ns; m_match = nm; m_err = ne;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // One compare process: every falling edge, all status outputs vs model.
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_bit_ready", bus.bit_ready, m_state == 1);
      check("cmp_busy",      bus.busy,      m_state != 0);
      check("cmp_done",      bus.done,      m_state == 2);
      check("cmp_state",     bus.state,     m_state);
      check("cmp_match",     bus.match,     m_match);
      check("cmp_match_cnt", bus.match_cnt, m_cnt);
      check("cmp_cfg_err",   bus.cfg_err,   m_err);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] pat, input logic [2:0] len,
                        input logic ovl, input logic [7:0] frame);
    bus.cfg_we = 1'b1; bus.cfg_pattern = pat; bus.cfg_len = len;
    bus.cfg_overlap = ovl; bus.cfg_frame = frame;
    cycle();
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1; bus.bit_in = b;
    cycle();
    bus.bit_valid = 1'b0;
  endtask

  task automatic stop_run();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 16 && bus.state != 2'd0; i++) cycle();
    check(name, bus.state, 2'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  logic [6:0] stream;
  logic [6:0] exp_m;
  int         acc;
  int         pulses;

  initial begin
    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.cfg_frame = '0; bus.start = 0; bus.stop = 0; bus.bit_valid = 0; bus.bit_in = 0;
    sbus.cfg_we = 0; sbus.cfg_pattern = '0; sbus.cfg_len = '0; sbus.cfg_overlap = 0;
    sbus.cfg_frame = '0; sbus.start = 0; sbus.stop = 0; sbus.bit_valid = 0; sbus.bit_in = 0;

    // Reset state
    #12;
    check("rst_state",     bus.state,     2'd0);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_bit_ready", bus.bit_ready, 1'b0);
    check("rst_match_cnt", bus.match_cnt, 8'd0);
    rst_n = 1'b1;
    cycle();

    // T4a: illegal length in IDLE -> cfg_err one cycle, length stays 2
    do_cfg(4'b1111, 3'd0, 1'b0, 8'd0);
    check("t4_err_len0",   bus.cfg_err, 1'b1);
    cycle();
    check("t4_err_clear",  bus.cfg_err, 1'b0);
    check("t4_model_len",  m_len, 2);

    // T1: reset config, bits 0,0,(gap),0,0
    start_run();
    check("t1_state_run",  bus.state, 2'd1);
    send_bit(1'b0);
    check("t1_match_b1",   bus.match, 1'b0);
    send_bit(1'b0);
    check("t1_match_b2",   bus.match, 1'b1);
    cycle();
    check("t1_match_gap",  bus.match, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("t1_match_b4",   bus.match, 1'b1);
    stop_run();
    check("t1_done",       bus.done, 1'b1);
    check("t1_cnt",        bus.match_cnt, 8'd2);
    check("t1_model_cnt",  m_cnt, 2);
    wait_idle("t1_idle");

    // T2: pattern 1011 len 4 overlapping, stream 1011011; cfg_we mid-run
    stream = 7'b1011011;
    exp_m  = 7'b0001001;
    do_cfg(4'b1011, 3'd4, 1'b1, 8'd0);
    start_run();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        do_cfg(4'b0000, 3'd1, 1'b0, 8'd0);
        check("t2_err_run", bus.cfg_err, 1'b1);
      end
      send_bit(stream[6-i]);
      check("t2_ovl_match", bus.match, exp_m[6-i]);
    end
    check("t2_ovl_cnt",   bus.match_cnt, 8'd2);
    check("t2_model_cnt", m_cnt, 2);
    stop_run();
    wait_idle("t2_idle_ovl");

    // Same stream, non-overlapping
    do_cfg(4'b1011, 3'd4, 1'b0, 8'd0);
    start_run();
    for (int i = 0; i < 7; i++) send_bit(stream[6-i]);
    check("t2_novl_cnt", bus.match_cnt, 8'd1);
    stop_run();
    wait_idle("t2_idle_novl");

    // T3: start+cfg_we together, frame of 5, 7 valid bits offered
    bus.cfg_we = 1; bus.cfg_pattern = 4'b1011; bus.cfg_len = 3'd4;
    bus.cfg_overlap = 0; bus.cfg_frame = 8'd5; bus.start = 1;
    cycle();
    bus.cfg_we = 0; bus.start = 0;
    check("t3_state_run", bus.state, 2'd1);
    stream = 7'b1011111;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      bus.bit_valid = 1'b1; bus.bit_in = stream[6-i];
      if (bus.bit_ready) acc++;
      if (i == 5) begin
        check("t3_done_after5", bus.done, 1'b1);
        check("t3_ready_low",   bus.bit_ready, 1'b0);
      end
      cycle();
    end
    bus.bit_valid = 1'b0;
    check("t3_accepted",    acc, 5);
    check("t3_model_nbits", m_nbits, 5);
    check("t3_idle",        bus.state, 2'd0);

    // Frame ends on the matching bit: match and done together
    do_cfg(4'b1011, 3'd4, 1'b0, 8'd4);
    start_run();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("t3_last_match", bus.match, 1'b1);
    check("t3_last_done",  bus.done, 1'b1);
    wait_idle("t3_idle_last");

    // Illegal start+cfg_we -> cfg_err, stay IDLE
    bus.cfg_we = 1; bus.cfg_len = 3'd5; bus.start = 1;
    cycle();
    bus.cfg_we = 0; bus.start = 0;
    check("t3_bad_start_err",   bus.cfg_err, 1'b1);
    check("t3_bad_start_state", bus.state, 2'd0);

    // Saturation of the 8-bit counter: len 1, pattern 0, 260 zeros
    do_cfg(4'b0000, 3'd1, 1'b0, 8'd0);
    start_run();
    bus.bit_valid = 1'b1; bus.bit_in = 1'b0;
    for (int i = 0; i < 260; i++) cycle();
    bus.bit_valid = 1'b0;
    check("sat8_cnt", bus.match_cnt, 8'd255);
    stop_run();
    wait_idle("sat8_idle");

    // T5: CNT_W=2 instance, 5 zero bits -> 5 pulses, count sticks at 3
    sbus.cfg_we = 1; sbus.cfg_pattern = 4'b0000; sbus.cfg_len = 3'd1;
    sbus.cfg_overlap = 0; sbus.cfg_frame = 8'd0;
    cycle();
    sbus.cfg_we = 0; sbus.start = 1;
    cycle();
    sbus.start = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      sbus.bit_valid = 1'b1; sbus.bit_in = 1'b0;
      cycle();
      if (sbus.match) pulses++;
    end
    sbus.bit_valid = 1'b0;
    check("t5_pulses", pulses, 5);
    check("t5_cnt",    sbus.match_cnt, 2'd3);
    sbus.stop = 1;
    cycle();
    sbus.stop = 0;
    check("t5_done",   sbus.done, 1'b1);

    // T6: reset mid-run after one match
    do_cfg(4'b0011, 3'd2, 1'b0, 8'd0);
    start_run();
    send_bit(1'b1); send_bit(1'b1);
    check("t6_pre_match", bus.match_cnt, 8'd1);
    send_bit(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_state",     bus.state,     2'd0);
    check("t6_rst_busy",      bus.busy,      1'b0);
    check("t6_rst_ready",     bus.bit_ready, 1'b0);
    check("t6_rst_cnt",       bus.match_cnt, 8'd0);
    check("t6_rst_match",     bus.match,     1'b0);
    check("t6_rst_done",      bus.done,      1'b0);
    check("t6_rst_err",       bus.cfg_err,   1'b0);
    #2 rst_n = 1'b1;
    cycle();

    // Next run uses reset config (00, len 2, non-overlap)
    start_run();
    send_bit(1'b1); send_bit(1'b1);
    check("t6_no_match_11", bus.match, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("t6_match_00",    bus.match, 1'b1);
    send_bit(1'b0);
    // stop with a simultaneous valid bit: bit completes a match, done next
    bus.stop = 1; bus.bit_valid = 1; bus.bit_in = 1'b0;
    cycle();
    bus.stop = 0; bus.bit_valid = 0;
    check("t6_stop_match", bus.match, 1'b1);
    check("t6_stop_done",  bus.done, 1'b1);
    check("t6_stop_cnt",   bus.match_cnt, 8'd2);
    wait_idle("t6_idle");
    cycle();
    check("t6_cnt_hold",   bus.match_cnt, 8'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
